// File: rtl/mac_lane_accum_if.sv
// Beat / result bundle for mac_lane_accum.
// master drives operand beats and observes results; slave is the MAC unit.
interface mac_lane_accum_if #(
    parameter int NUM_LANES = 2,
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 32
);
    logic                           in_valid;
    logic                           in_last;
    logic [NUM_LANES*A_WIDTH-1:0]   dataa;
    logic [NUM_LANES*B_WIDTH-1:0]   datab;
    logic [ACC_WIDTH-1:0]           result;
    logic                           result_valid;
    logic                           overflow;

    modport master (
        output in_valid, in_last, dataa, datab,
        input  result, result_valid, overflow
    );

    modport slave (
        input  in_valid, in_last, dataa, datab,
        output result, result_valid, overflow
    );
endinterface

// File: rtl/mac_lane_accum.sv
// N-lane multiply-accumulate: registered per-lane products, pipelined adder
// tree, accumulator stage and registered result stage.
// Compile-time option: define MAC_SATURATE_EN to clamp the accumulator on
// overflow instead of wrapping.

// Per-lane product, width A_WIDTH+B_WIDTH, operands extended per SIGNED.
module mac_lane_mul #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int SIGNED  = 1,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] p
);
    logic [P_WIDTH-1:0] ae, be;

    if (SIGNED != 0) begin : g_sext
        assign ae = {{B_WIDTH{a[A_WIDTH-1]}}, a};
        assign be = {{A_WIDTH{b[B_WIDTH-1]}}, b};
    end else begin : g_zext
        assign ae = {{B_WIDTH{1'b0}}, a};
        assign be = {{A_WIDTH{1'b0}}, b};
    end

    // Low P_WIDTH bits of the extended product are exact in both modes.
    assign p = ae * be;
endmodule

module mac_lane_accum #(
    parameter int NUM_LANES = 2,
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int SIGNED    = 1
) (
    input  logic                  clock0,
    input  logic                  reset,
    mac_lane_accum_if.slave       bus
);
    localparam int PW     = A_WIDTH + B_WIDTH;
    localparam int LEVELS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 0;
    localparam int STAGES = LEVELS;
    localparam int P2     = 1 << LEVELS;        // lanes padded to a power of two
    localparam int SW     = PW + LEVELS;        // tree result width
    localparam int EXT    = ACC_WIDTH - SW;
    localparam int MSB    = ACC_WIDTH - 1;
`ifdef MAC_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic [NUM_LANES-1:0][PW-1:0] prod;
    logic [P2-1:0][SW-1:0]        leaf;
    // Heap-ordered tree: node 0 is the root, leaves live at P2-1 .. 2*P2-2.
    logic [2*P2-2:0][SW-1:0]      node;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0]              lst_pipe;

    logic [ACC_WIDTH-1:0] acc, base, sum_ext, raw, sat_val, acc_nxt;
    logic                 carry, ovf_now;
    logic                 first, sticky, fin, fin_ovf;

    for (genvar g = 0; g < P2; g++) begin : g_lane
        if (g < NUM_LANES) begin : g_real
            mac_lane_mul #(
                .A_WIDTH (A_WIDTH),
                .B_WIDTH (B_WIDTH),
                .SIGNED  (SIGNED)
            ) u_lane (
                .a (bus.dataa[g*A_WIDTH +: A_WIDTH]),
                .b (bus.datab[g*B_WIDTH +: B_WIDTH]),
                .p (prod[g])
            );
            if (LEVELS == 0) begin : g_noext
                assign leaf[g] = prod[g];
            end else if (SIGNED != 0) begin : g_sext
                assign leaf[g] = {{LEVELS{prod[g][PW-1]}}, prod[g]};
            end else begin : g_zext
                assign leaf[g] = {{LEVELS{1'b0}}, prod[g]};
            end
        end else begin : g_pad
            assign leaf[g] = '0;
        end
    end

    if (EXT == 0) begin : g_sum_noext
        assign sum_ext = node[0];
    end else if (SIGNED != 0) begin : g_sum_sext
        assign sum_ext = {{EXT{node[0][SW-1]}}, node[0]};
    end else begin : g_sum_zext
        assign sum_ext = {{EXT{1'b0}}, node[0]};
    end

    // Product registers (leaves) and one registered tree level per depth.
    always_ff @(posedge clock0) begin
        for (int i = 0; i < P2; i++) node[P2-1+i] <= leaf[i];
        for (int i = 0; i < P2-1; i++) node[i] <= node[2*i+1] + node[2*i+2];
    end

    // Next accumulator value, overflow detection and optional clamping.
    always_comb begin
        base         = first ? '0 : acc;
        {carry, raw} = {1'b0, base} + {1'b0, sum_ext};
        if (SIGNED != 0) begin
            ovf_now = (base[MSB] == sum_ext[MSB]) && (raw[MSB] != base[MSB]);
            sat_val = base[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            ovf_now = carry;
            sat_val = '1;
        end
        acc_nxt = raw;
        if (SATURATE && ovf_now) acc_nxt = sat_val;
    end

    // valid/last shift alongside the tree; accumulate when a beat reaches the root.
    always_ff @(posedge clock0) begin
        if (reset) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
            acc      <= '0;
            first    <= 1'b1;
            sticky   <= 1'b0;
            fin      <= 1'b0;
            fin_ovf  <= 1'b0;
        end else begin
            vld_pipe[0] <= bus.in_valid;
            lst_pipe[0] <= bus.in_valid & bus.in_last;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                lst_pipe[k] <= lst_pipe[k-1];
            end
            fin <= 1'b0;
            if (vld_pipe[STAGES]) begin
                acc <= acc_nxt;
                if (lst_pipe[STAGES]) begin
                    first   <= 1'b1;
                    sticky  <= 1'b0;
                    fin     <= 1'b1;
                    fin_ovf <= sticky | ovf_now;
                end else begin
                    first   <= 1'b0;
                    sticky  <= sticky | ovf_now;
                end
            end
        end
    end

    // Registered result: capture the finished accumulator, pulse valid once.
    always_ff @(posedge clock0) begin
        if (reset) begin
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.overflow     <= 1'b0;
        end else begin
            bus.result_valid <= fin;
            if (fin) begin
                bus.result   <= acc;
                bus.overflow <= fin_ovf;
            end
        end
    end
endmodule

// File: tb/tb_mac_lane_accum.sv
// Self-checking bench for mac_lane_accum: three instances (2-lane signed 32b,
// 2-lane signed 18b, 3-lane unsigned 18b), table-driven beats feeding a
// per-instance scoreboard, plus hand-written reset sequences.
module tb_mac_lane_accum;
    logic clock0 = 1'b0;
    logic reset  = 1'b1;
    always #5 clock0 = ~clock0;

    int cyc = 0;
    always @(posedge clock0) cyc <= cyc + 1;

    int nvec  = 0;
    int nfail = 0;

`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int LAT0 = 3, LAT1 = 3, LAT2 = 4;

    typedef struct {
        int          bus;
        logic [23:0] a;
        logic [23:0] b;
        bit          last;
        int          gap;
        logic [31:0] res;
        bit          ovf;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        bit          ovf;
        int          cyc;
    } exp_t;

    vec_t tbl[$];
    exp_t q0[$], q1[$], q2[$];

    mac_lane_accum_if #(.NUM_LANES(2), .ACC_WIDTH(32)) bus0 ();
    mac_lane_accum_if #(.NUM_LANES(2), .ACC_WIDTH(18)) bus1 ();
    mac_lane_accum_if #(.NUM_LANES(3), .ACC_WIDTH(18)) bus2 ();

    mac_lane_accum #(.NUM_LANES(2), .ACC_WIDTH(32), .SIGNED(1)) u_dut0 (
        .clock0 (clock0), .reset (reset), .bus (bus0.slave));
    mac_lane_accum #(.NUM_LANES(2), .ACC_WIDTH(18), .SIGNED(1)) u_dut1 (
        .clock0 (clock0), .reset (reset), .bus (bus1.slave));
    mac_lane_accum #(.NUM_LANES(3), .ACC_WIDTH(18), .SIGNED(0)) u_dut2 (
        .clock0 (clock0), .reset (reset), .bus (bus2.slave));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic idle_all();
        bus0.in_valid = 1'b0; bus0.in_last = 1'b0; bus0.dataa = '0; bus0.datab = '0;
        bus1.in_valid = 1'b0; bus1.in_last = 1'b0; bus1.dataa = '0; bus1.datab = '0;
        bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.dataa = '0; bus2.datab = '0;
    endtask

    task automatic set_bus(int bus, bit v, bit l, logic [23:0] a, logic [23:0] b);
        case (bus)
            0: begin bus0.in_valid = v; bus0.in_last = l; bus0.dataa = a[15:0]; bus0.datab = b[15:0]; end
            1: begin bus1.in_valid = v; bus1.in_last = l; bus1.dataa = a[15:0]; bus1.datab = b[15:0]; end
            default: begin bus2.in_valid = v; bus2.in_last = l; bus2.dataa = a; bus2.datab = b; end
        endcase
    endtask

    // Called at the negedge a last beat is driven; it is sampled at the next edge.
    task automatic push(int bus, logic [31:0] res, bit ovf);
        exp_t e;
        e.res = res;
        e.ovf = ovf;
        case (bus)
            0: begin e.cyc = cyc + 1 + LAT0; q0.push_back(e); end
            1: begin e.cyc = cyc + 1 + LAT1; q1.push_back(e); end
            default: begin e.cyc = cyc + 1 + LAT2; q2.push_back(e); end
        endcase
    endtask

    task automatic add(int bus, logic [23:0] a, logic [23:0] b, bit last, int gap,
                       logic [31:0] res, bit ovf);
        vec_t v;
        v.bus = bus; v.a = a; v.b = b; v.last = last; v.gap = gap; v.res = res; v.ovf = ovf;
        tbl.push_back(v);
    endtask

    // Scoreboard pop and compare for each instance.
    always @(negedge clock0) begin
        if (bus0.result_valid === 1'b1) begin
            if (q0.size() == 0) chk("pulse0_unexpected", 32'(bus0.result_valid), 32'd0);
            else begin
                exp_t e;
                e = q0.pop_front();
                chk("result0", 32'(bus0.result), e.res);
                chk("overflow0", 32'(bus0.overflow), 32'(e.ovf));
                chk("latency0", cyc, e.cyc);
            end
        end
    end

    always @(negedge clock0) begin
        if (bus1.result_valid === 1'b1) begin
            if (q1.size() == 0) chk("pulse1_unexpected", 32'(bus1.result_valid), 32'd0);
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("result1", 32'(bus1.result), 32'(e.res[17:0]));
                chk("overflow1", 32'(bus1.overflow), 32'(e.ovf));
                chk("latency1", cyc, e.cyc);
            end
        end
    end

    always @(negedge clock0) begin
        if (bus2.result_valid === 1'b1) begin
            if (q2.size() == 0) chk("pulse2_unexpected", 32'(bus2.result_valid), 32'd0);
            else begin
                exp_t e;
                e = q2.pop_front();
                chk("result2", 32'(bus2.result), 32'(e.res[17:0]));
                chk("overflow2", 32'(bus2.overflow), 32'(e.ovf));
                chk("latency2", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_all();
        reset = 1'b1;
        repeat (3) @(negedge clock0);
        reset = 1'b0;

        chk("reset_result0", 32'(bus0.result), 32'd0);
        chk("reset_valid0", 32'(bus0.result_valid), 32'd0);
        chk("reset_ovf0", 32'(bus0.overflow), 32'd0);
        chk("reset_result1", 32'(bus1.result), 32'd0);
        chk("reset_valid1", 32'(bus1.result_valid), 32'd0);
        chk("reset_ovf1", 32'(bus1.overflow), 32'd0);
        chk("reset_result2", 32'(bus2.result), 32'd0);
        chk("reset_valid2", 32'(bus2.result_valid), 32'd0);
        chk("reset_ovf2", 32'(bus2.overflow), 32'd0);

        // Single beat {1,1}.{1,1}
        add(0, 24'h0101, 24'h0101, 1, 0, 2, 0);
        // Four beats {3,-2}.{5,7} = 1 each
        for (int i = 0; i < 3; i++) add(0, 24'h03FE, 24'h0507, 0, 0, 0, 0);
        add(0, 24'h03FE, 24'h0507, 1, 2, 4, 0);
        // Same with bubbles between beats
        for (int i = 0; i < 3; i++) add(0, 24'h03FE, 24'h0507, 0, 2, 0, 0);
        add(0, 24'h03FE, 24'h0507, 1, 0, 4, 0);
        // Back-to-back: one-beat product then two-beat product, no bubble
        add(0, 24'h0101, 24'h0101, 1, 0, 2, 0);
        add(0, 24'h0101, 24'h0101, 0, 0, 0, 0);
        add(0, 24'h0101, 24'h0101, 1, 0, 4, 0);
        // Negative result: {-128,-128}.{127,127}
        add(0, 24'h8080, 24'h7F7F, 1, 0, -32512, 0);
        // 18-bit signed: five beats of 32258 overflow on the last beat
        for (int i = 0; i < 4; i++) add(1, 24'h7F7F, 24'h7F7F, 0, 0, 0, 0);
        add(1, 24'h7F7F, 24'h7F7F, 1, 0, SAT ? 131071 : -100854, 1);
        // Overflow on beat 5 must stay sticky through a zero final beat
        for (int i = 0; i < 5; i++) add(1, 24'h7F7F, 24'h7F7F, 0, 0, 0, 0);
        add(1, 24'h007F, 24'h0000, 1, 0, SAT ? 131071 : -100854, 1);
        // Sticky flag and accumulator start clean for the next product
        add(1, 24'h0101, 24'h0101, 1, 0, 2, 0);
        // 3 lanes unsigned: padding lane, zero-extension, carry overflow
        add(2, 24'h010203, 24'h040506, 1, 0, 32, 0);
        add(2, 24'hFFFFFF, 24'h010101, 1, 0, 765, 0);
        add(2, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 0, 0);
        add(2, 24'hFFFFFF, 24'hFFFFFF, 1, 0, SAT ? 262143 : 128006, 1);
        add(2, 24'h010203, 24'h040506, 1, 0, 32, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock0);
            idle_all();
            set_bus(tbl[i].bus, 1'b1, tbl[i].last, tbl[i].a, tbl[i].b);
            if (tbl[i].last) push(tbl[i].bus, tbl[i].res, tbl[i].ovf);
            repeat (tbl[i].gap) begin
                @(negedge clock0);
                idle_all();
            end
        end
        @(negedge clock0);
        idle_all();
        repeat (8) @(negedge clock0);
        chk("drain_table0", q0.size(), 0);
        chk("drain_table1", q1.size(), 0);
        chk("drain_table2", q2.size(), 0);

        // Reset after beat 2 of a 4-beat product; a last beat offered during reset.
        @(negedge clock0); set_bus(0, 1'b1, 1'b0, 24'h03FE, 24'h0507);
        @(negedge clock0); set_bus(0, 1'b1, 1'b0, 24'h03FE, 24'h0507);
        @(negedge clock0); reset = 1'b1; set_bus(0, 1'b1, 1'b1, 24'h0101, 24'h0101);
        @(negedge clock0); reset = 1'b0; idle_all();
        chk("midrst_result0", 32'(bus0.result), 32'd0);
        chk("midrst_valid0", 32'(bus0.result_valid), 32'd0);
        chk("midrst_ovf1", 32'(bus1.overflow), 32'd0);
        repeat (6) @(negedge clock0);
        set_bus(0, 1'b1, 1'b1, 24'h0101, 24'h0101);
        push(0, 2, 0);
        @(negedge clock0); idle_all();
        repeat (6) @(negedge clock0);

        // Reset while a last beat is still in the pipeline: no result for it.
        set_bus(0, 1'b1, 1'b1, 24'h0101, 24'h0101);
        @(negedge clock0); reset = 1'b1; idle_all();
        @(negedge clock0); reset = 1'b0;
        chk("flightrst_result0", 32'(bus0.result), 32'd0);
        repeat (8) @(negedge clock0);

        chk("drain_final0", q0.size(), 0);
        chk("drain_final1", q1.size(), 0);
        chk("drain_final2", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
